// File: rtl/jtag_host_pkg.sv
// Shared definitions for the uP debug JTAG host: command codes,
// phase lengths, FSM encoding and per-slot TMS/TDI helpers.
package jtag_host_pkg;

    // Target command codes
    localparam logic [7:0] CMD_ADDR     = 8'h01;
    localparam logic [7:0] CMD_MEM_RD   = 8'h02;
    localparam logic [7:0] CMD_MEM_WR   = 8'h03;
    localparam logic [7:0] CMD_ACC_SCAN = 8'h04;
    localparam logic [7:0] CMD_ACC_SPI  = 8'h05;
    localparam logic [7:0] CMD_UNPAUSE  = 8'h06;
    localparam logic [7:0] CMD_PAUSE    = 8'h07;

    // Phase lengths in TCK pulses
    localparam int DATA_LEN = 19;
    localparam int CMD_LEN  = 11;

    // Index of the final slot of each phase
    localparam logic [4:0] DATA_LAST = 5'(DATA_LEN - 1);
    localparam logic [4:0] CMD_LAST  = 5'(CMD_LEN - 1);

    // Host FSM states
    typedef enum logic [2:0] {
        sIdle = 3'd0,
        sWph  = 3'd1,
        sCph  = 3'd2,
        sRph  = 3'd3,
        sRsp  = 3'd4
    } jtagStateT;

    // Request latched at accept
    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic        wrData;
        logic        rdData;
    } jtagReqT;

    // {TMS,TDI} for a data-phase slot: 1,1,0 then 16 shift slots MSB first
    function automatic logic [1:0] dataSlot(input logic [4:0] idx,
                                            input logic [15:0] d);
        logic tmsV;
        logic tdiV;
        tmsV = (idx < 5'd2) || (idx == DATA_LAST);
        tdiV = (idx >= 5'd3) ? d[4'(DATA_LAST - idx)] : 1'b0;
        return {tmsV, tdiV};
    endfunction

    // {TMS,TDI} for a cmd-phase slot: 1,0 then 8 cmd slots, then exit
    function automatic logic [1:0] cmdSlot(input logic [4:0] idx,
                                           input logic [7:0] c);
        logic tmsV;
        logic tdiV;
        tmsV = (idx == 5'd0) || (idx == 5'd9);
        tdiV = (idx >= 5'd2 && idx <= 5'd9) ? c[3'(5'd9 - idx)] : 1'b0;
        return {tmsV, tdiV};
    endfunction

endpackage

// File: rtl/jtag_host_if.sv
// Request/response bundle between the debug bridge and the JTAG host.
// master = requester, slave = jtag_host.
interface jtag_host_if;

    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqCmd;
    logic [15:0] reqData;
    logic        reqWrData;
    logic        reqRdData;
    logic        rspValid;
    logic [15:0] rspData;
    logic [1:0]  rspStatus;
    logic        busy;

    modport master (
        output reqValid, reqCmd, reqData, reqWrData, reqRdData,
        input  reqReady, rspValid, rspData, rspStatus, busy
    );

    modport slave (
        input  reqValid, reqCmd, reqData, reqWrData, reqRdData,
        output reqReady, rspValid, rspData, rspStatus, busy
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: TCK_DIV clocks low, TCK_DIV clocks high per pulse.
// Once high, TCK always completes its falling edge even if en drops.
module jtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(TCK_DIV);

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(TCK_DIV - 1));
    assign rise = en && !tck && last;
    assign fall = tck && last;

    // half-period counter and TCK level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (en || tck) begin
            if (last) begin
                cnt <= '0;
                tck <= ~tck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG debug host: serialises one request into TCK/TMS/TDI phases.
// Define JTAG_HOST_STATUS_EN to capture {paused,booted} into rspStatus.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int TCK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    jtag_host_if.slave bus,
    output logic       o_TCK,
    output logic       o_TMS,
    output logic       o_TDI,
    input  logic       i_TDO
);

    jtagStateT   state;
    jtagStateT   stateNext;
    logic [4:0]  bitCnt;
    logic [4:0]  bitNext;
    jtagReqT     req;
    logic        tmsQ;
    logic        tdiQ;
    logic        tmsNext;
    logic        tdiNext;
    logic [15:0] shiftQ;
    logic [15:0] rspDataQ;
    logic        tdoMeta;
    logic        tdoSync;
    logic        tckEn;
    logic        rise;
    logic        fall;
    logic        accept;
    logic        loadRsp;
    logic        inShift;

    assign accept = bus.reqValid && (state == sIdle);
    assign tckEn  = (state == sWph) || (state == sCph) || (state == sRph);
    assign inShift = ((state == sWph) || (state == sRph))
                     && (bitCnt >= 5'd3);

    jtag_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) uTck (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (tckEn),
        .tck  (o_TCK),
        .rise (rise),
        .fall (fall)
    );

    // next state, slot index and next-slot pin values
    always_comb begin
        stateNext = state;
        bitNext   = bitCnt;
        tmsNext   = tmsQ;
        tdiNext   = tdiQ;
        loadRsp   = 1'b0;
        unique case (state)
            sIdle: begin
                if (accept) begin
                    bitNext = '0;
                    if (bus.reqWrData) begin
                        stateNext = sWph;
                        {tmsNext, tdiNext} = dataSlot(5'd0, bus.reqData);
                    end else begin
                        stateNext = sCph;
                        {tmsNext, tdiNext} = cmdSlot(5'd0, bus.reqCmd);
                    end
                end
            end
            sWph: begin
                if (fall) begin
                    if (bitCnt == DATA_LAST) begin
                        stateNext = sCph;
                        bitNext   = '0;
                        {tmsNext, tdiNext} = cmdSlot(5'd0, req.cmd);
                    end else begin
                        bitNext = bitCnt + 5'd1;
                        {tmsNext, tdiNext} = dataSlot(bitNext, req.data);
                    end
                end
            end
            sCph: begin
                if (fall) begin
                    if (bitCnt == CMD_LAST) begin
                        bitNext = '0;
                        if (req.rdData) begin
                            stateNext = sRph;
                            {tmsNext, tdiNext} = dataSlot(5'd0, 16'h0000);
                        end else begin
                            stateNext = sRsp;
                            {tmsNext, tdiNext} = 2'b00;
                            loadRsp = 1'b1;
                        end
                    end else begin
                        bitNext = bitCnt + 5'd1;
                        {tmsNext, tdiNext} = cmdSlot(bitNext, req.cmd);
                    end
                end
            end
            sRph: begin
                if (fall) begin
                    if (bitCnt == DATA_LAST) begin
                        stateNext = sRsp;
                        bitNext   = '0;
                        {tmsNext, tdiNext} = 2'b00;
                        loadRsp = 1'b1;
                    end else begin
                        bitNext = bitCnt + 5'd1;
                        {tmsNext, tdiNext} = dataSlot(bitNext, 16'h0000);
                    end
                end
            end
            sRsp: begin
                stateNext = sIdle;
            end
            default: begin
                stateNext = sIdle;
            end
        endcase
    end

    // FSM state, slot counter and registered TMS/TDI pins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= sIdle;
            bitCnt <= '0;
            tmsQ   <= 1'b0;
            tdiQ   <= 1'b0;
        end else begin
            state  <= stateNext;
            bitCnt <= bitNext;
            tmsQ   <= tmsNext;
            tdiQ   <= tdiNext;
        end
    end

    // latch the request so inputs may change once accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req <= '0;
        end else if (accept) begin
            req <= '{cmd:    bus.reqCmd,
                     data:   bus.reqData,
                     wrData: bus.reqWrData,
                     rdData: bus.reqRdData};
        end
    end

    // two-flop TDO synchroniser
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tdoMeta <= 1'b0;
            tdoSync <= 1'b0;
        end else begin
            tdoMeta <= i_TDO;
            tdoSync <= tdoMeta;
        end
    end

    // TDO capture of data shift slots; last data phase wins
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shiftQ <= '0;
        end else if (accept) begin
            shiftQ <= '0;
        end else if (rise && inShift) begin
            shiftQ <= {shiftQ[14:0], tdoSync};
        end
    end

    // response data, held until the next transaction ends
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rspDataQ <= '0;
        end else if (loadRsp) begin
            rspDataQ <= shiftQ;
        end
    end

`ifdef JTAG_HOST_STATUS_EN
    logic [1:0] statusQ;

    // {paused,booted} arrive on the last two cmd shift edges
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            statusQ <= 2'b00;
        end else if (rise && (state == sCph)) begin
            if (bitCnt == 5'd8) begin
                statusQ[1] <= tdoSync;
            end
            if (bitCnt == 5'd9) begin
                statusQ[0] <= tdoSync;
            end
        end
    end

    assign bus.rspStatus = statusQ;
`else
    assign bus.rspStatus = 2'b00;
`endif

    assign bus.reqReady = (state == sIdle);
    assign bus.busy     = (state != sIdle);
    assign bus.rspValid = (state == sRsp);
    assign bus.rspData  = rspDataQ;
    assign o_TMS        = tmsQ;
    assign o_TDI        = tdiQ;

endmodule
